// File: rtl/mips_defs.sv
// Shared CP0 definitions: register numbers, field positions and exception codes.
package mips_defs;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE_BIT    = 0;
  localparam int unsigned SR_EXL_BIT   = 1;
  localparam int unsigned IM_LO        = 10;
  localparam int unsigned IM_HI        = 15;
  localparam int unsigned CAUSE_BD_BIT = 31;
  localparam int unsigned EXC_LO       = 2;
  localparam int unsigned EXC_HI       = 6;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/cp0.sv
// System-control coprocessor: SR/Cause/EPC/PRId, interrupt/exception request,
// mtc0/mfc0/eret service from the M stage.
module cp0
  import mips_defs::*;
#(
  parameter logic [31:0] PRID = 32'h0000_2019
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hwint,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc;
  logic [31:2] r_epc;

  logic        w_int_pend;
  logic        w_exc_pend;
  logic [31:0] w_epc_full;
  logic        w_unused_ok;

  assign w_int_pend  = r_ie & (|(hwint & r_im));
  assign w_exc_pend  = (exc_code != 5'd0);
  assign req         = ~r_exl & (w_int_pend | w_exc_pend);
  // Delay-slot instructions restart at the branch; subtraction wraps at 32 bits.
  assign w_epc_full  = bd ? (pc - 32'd4) : pc;
  assign w_unused_ok = &{1'b0, w_epc_full[1:0]};
  assign epc         = {r_epc, 2'b00};

  // Register update: exception entry beats mtc0; eret clears EXL after any SR write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_im  <= 6'd0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= 6'd0;
      r_exc <= 5'd0;
      r_epc <= 30'd0;
    end else begin
      r_ip <= hwint;
      if (req) begin
        r_exl <= 1'b1;
        r_bd  <= bd;
        r_exc <= w_int_pend ? EXC_INT : exc_code;
        r_epc <= w_epc_full[31:2];
      end else begin
        if (we && (addr == REG_SR)) begin
          r_im  <= wdata[IM_HI:IM_LO];
          r_exl <= wdata[SR_EXL_BIT];
          r_ie  <= wdata[SR_IE_BIT];
        end
        if (we && (addr == REG_EPC)) begin
          r_epc <= wdata[31:2];
        end
        if (eret) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux; reflects state before the current edge.
  always_comb begin
    rdata = 32'd0;
    case (addr)
      REG_SR: begin
        rdata[IM_HI:IM_LO] = r_im;
        rdata[SR_EXL_BIT]  = r_exl;
        rdata[SR_IE_BIT]   = r_ie;
      end
      REG_CAUSE: begin
        rdata[CAUSE_BD_BIT]  = r_bd;
        rdata[IM_HI:IM_LO]   = r_ip;
        rdata[EXC_HI:EXC_LO] = r_exc;
      end
      REG_EPC:  rdata = {r_epc, 2'b00};
      REG_PRID: rdata = PRID;
      default:  rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: hand-computed register images after each step.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_code;
  logic [5:0]  hwint;
  logic        eret;
  logic        req;
  logic [31:0] epc;

  int n_vec;
  int n_bad;

  cp0 dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .pc       (pc),
    .bd       (bd),
    .exc_code (exc_code),
    .hwint    (hwint),
    .eret     (eret),
    .req      (req),
    .epc      (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0; pc = 32'd0;
    bd = 1'b0; exc_code = 5'd0; hwint = 6'h3F; eret = 1'b0;

    // Reset held for two edges
    step; step;
    reset = 1'b1;
    rd("rst_sr", 5'd12, 32'h0000_0000);
    rd("rst_cause", 5'd13, 32'h0000_0000);
    rd("rst_epc", 5'd14, 32'h0000_0000);
    rd("rst_prid", 5'd15, 32'h0000_2019);
    rd("rst_other", 5'd3, 32'h0000_0000);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_epc_out", epc, 32'd0);

    // Enable IM[0] and IE
    hwint = 6'd0; we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    step;
    we = 1'b0;
    rd("ie_sr", 5'd12, 32'h0000_0401);
    chk("ie_req_idle", {31'd0, req}, 32'd0);
    hwint = 6'b000001; pc = 32'h0000_3010; bd = 1'b0;
    #1;
    chk("ie_req_fire", {31'd0, req}, 32'd1);
    step;
    chk("ie_req_after", {31'd0, req}, 32'd0);
    rd("ie_sr_exl", 5'd12, 32'h0000_0403);
    rd("ie_epc", 5'd14, 32'h0000_3010);
    rd("ie_cause", 5'd13, 32'h0000_0400);

    // Clear SR (write allowed while EXL=1), then delay-slot overflow
    hwint = 6'd0; we = 1'b1; addr = 5'd12; wdata = 32'h0000_0000;
    step;
    we = 1'b0;
    exc_code = 5'd12; bd = 1'b1; pc = 32'h0000_3004;
    #1;
    chk("ds_req_fire", {31'd0, req}, 32'd1);
    step;
    exc_code = 5'd0;
    rd("ds_epc", 5'd14, 32'h0000_3000);
    rd("ds_cause", 5'd13, 32'h8000_0030);
    rd("ds_sr", 5'd12, 32'h0000_0002);

    // EXL masks exceptions
    exc_code = 5'd10;
    #1;
    chk("mask_req", {31'd0, req}, 32'd0);
    exc_code = 5'd0;

    // SR write together with eret: write applies, EXL forced to 0
    hwint = 6'b000001; we = 1'b1; addr = 5'd12; wdata = 32'h0000_0403; eret = 1'b1;
    step;
    we = 1'b0; eret = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    chk("eret_req_again", {31'd0, req}, 32'd1);
    rd("eret_cause", 5'd13, 32'h8000_0430);

    // mtc0 EPC colliding with req: exception PC wins
    bd = 1'b0; pc = 32'h0000_4008; we = 1'b1; addr = 5'd14; wdata = 32'h1234_5677;
    step;
    rd("coll_epc", 5'd14, 32'h0000_4008);
    rd("coll_cause", 5'd13, 32'h0000_0400);
    addr = 5'd14;
    step;
    we = 1'b0;
    rd("mtc0_epc", 5'd14, 32'h1234_5674);
    chk("mtc0_epc_out", epc, 32'h1234_5674);

    // eret with req on the same edge, pc=0 in delay slot wraps
    eret = 1'b1;
    step;
    chk("eret2_req", {31'd0, req}, 32'd1);
    bd = 1'b1; pc = 32'h0000_0000;
    step;
    eret = 1'b0; bd = 1'b0;
    rd("wrap_sr", 5'd12, 32'h0000_0403);
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0400);
    chk("wrap_req", {31'd0, req}, 32'd0);

    // Write to Cause is ignored
    we = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
    step;
    we = 1'b0;
    rd("cause_ro", 5'd13, 32'h8000_0400);

    // Mid-operation reset
    reset = 1'b0;
    step;
    reset = 1'b1;
    rd("mrst_sr", 5'd12, 32'h0000_0000);
    rd("mrst_cause", 5'd13, 32'h0000_0000);
    rd("mrst_epc", 5'd14, 32'h0000_0000);
    chk("mrst_req", {31'd0, req}, 32'd0);
    chk("mrst_epc_out", epc, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
